// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-at-a-time arbiter of fetch and load/store onto a single memory port
// ARB_ROUND_ROBIN_EN: alternate owners on contention; undefined gives data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state;
  logic                owner_d;
  logic [CNT_W-1:0]    wd_cnt;
  logic [CNT_W-1:0]    wd_nxt;
  logic                wd_expire;
  logic                pick_d;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [DATA_W/8-1:0] win_be;
  logic [DATA_W-1:0]   rsp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // On contention the side that did not own the previous transaction wins.
  always_comb pick_d = bus.d_req && (!bus.if_req || !last_d);
`else
  always_comb pick_d = bus.d_req;
`endif

  always_comb begin
    win_we    = 1'b0;
    win_addr  = bus.if_addr;
    win_wdata = '0;
    win_be    = '1;
    if (pick_d) begin
      win_we    = bus.d_we;
      win_addr  = bus.d_addr;
      win_wdata = bus.d_wdata;
      win_be    = bus.d_be;
    end
  end

  always_comb begin
    bus.if_gnt = 1'b0;
    bus.d_gnt  = 1'b0;
    if (rst_n && state == IDLE) begin
      bus.d_gnt  = pick_d;
      bus.if_gnt = bus.if_req && !pick_d;
    end
  end

  // Saturating watchdog; expiry is judged on the value it would take this cycle.
  always_comb begin
    wd_nxt    = (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;
    wd_expire = (TIMEOUT != 0) && (32'(wd_nxt) == TIMEOUT);
    rsp_data  = bus.mem_we ? '0 : bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      wd_cnt        <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d        <= 1'b0;
`endif
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= win_we;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            bus.mem_be    <= win_be;
            owner_d       <= pick_d;
            wd_cnt        <= '0;
            state         <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= pick_d;
`endif
          end
        end
        BUSY: begin
          wd_cnt <= wd_nxt;
          // Response is launched on the same edge that leaves BUSY, so rvalid is high during RESP.
          if (bus.mem_ack || wd_expire) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner_d) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= bus.mem_ack ? rsp_data : '0;
              bus.d_err    <= !bus.mem_ack;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_ack ? rsp_data : '0;
              bus.if_err    <= !bus.mem_ack;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
